// File: rtl/flap_input_conditioner_pkg.sv
// rtl/flap_input_conditioner_pkg.sv - game-state encodings, clock rate and FSM states for the flap input path
package flap_input_conditioner_pkg;

    localparam int CLK_HZ = 50_000_000;

    localparam logic [3:0] GS_START_SCREEN = 4'b0001;
    localparam logic [3:0] GS_IN_GAME      = 4'b0010;
    localparam logic [3:0] GS_PAUSE        = 4'b0100;
    localparam logic [3:0] GS_END_SCREEN   = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COOLDOWN = 2'd1,
        ST_HELD     = 2'd2
    } flap_state_e;

    // Any non-one-hot value counts as closed so a corrupted game_state cannot flap the bird.
    function automatic logic gate_is_open(input logic [3:0] gs);
        logic open;
        case (gs)
            GS_START_SCREEN, GS_IN_GAME: open = 1'b1;
            GS_PAUSE, GS_END_SCREEN:     open = 1'b0;
            default:                     open = 1'b0;
        endcase
        return open;
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// rtl/key_debouncer.sv - metastability synchroniser and stability-counter debouncer for the FLAP key
module key_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic key_level
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [DW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   sync_pressed;

    assign sync_pressed = ~sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], key_n};
        cnt_d   = '0;
        level_d = level_q;
        if (sync_pressed != level_q) begin
            if (cnt_q == DEB_LAST) begin
                level_d = sync_pressed;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '1;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign key_level = level_q;

endmodule

// File: rtl/flap_input_conditioner.sv
// rtl/flap_input_conditioner.sv - FLAP key to one-cycle flap pulse with cooldown, gating and HUD counter
// Optional hold-to-repeat flapping is enabled by defining FLAP_AUTOREPEAT_EN.
module flap_input_conditioner
    import flap_input_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = CLK_HZ / 100,
    parameter int COOLDOWN_CYCLES = CLK_HZ / 20,
    parameter int REPEAT_CYCLES   = CLK_HZ / 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_n,
    input  logic [3:0]  game_state,
    output logic        flap,
    output logic        key_level,
    output logic [15:0] flap_count
);

    localparam int CW = $clog2(COOLDOWN_CYCLES + 1);
    localparam logic [CW-1:0] COOL_LAST = CW'(COOLDOWN_CYCLES - 1);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2 || COOLDOWN_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_params
        $error("flap_input_conditioner: every stage/cycle parameter must be at least 2");
    end

    logic        key_level_w;
    logic        key_level_prev_q, key_level_prev_d;
    logic        rise_q, rise_d;
    logic        flap_q, flap_d;
    logic [15:0] flap_count_q, flap_count_d;
    logic [CW-1:0] cool_cnt_q, cool_cnt_d;
    flap_state_e state_q, state_d;
    logic        gate_open;
    logic        cool_done;
    logic        rep_fire;

    key_debouncer #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debouncer (
        .clk      (clk),
        .rst      (rst),
        .key_n    (key_n),
        .key_level(key_level_w)
    );

    assign gate_open = gate_is_open(game_state);

    // The flap cycle itself does not count, so the cooldown spans COOLDOWN_CYCLES+1 cycles.
    assign cool_done = (state_q == ST_COOLDOWN) && !flap_q && (cool_cnt_q == COOL_LAST);

`ifdef FLAP_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rep_cnt_q, rep_cnt_d;

    assign rep_fire = (state_q == ST_HELD) && key_level_w && gate_open && (rep_cnt_q == REP_LAST);

    always_comb begin
        rep_cnt_d = '0;
        if (state_q == ST_HELD && gate_open && !rep_fire) begin
            rep_cnt_d = rep_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_cnt_q <= '0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (rise_q) begin
                    state_d = gate_open ? ST_COOLDOWN : ST_HELD;
                end
            end
            ST_COOLDOWN: begin
                if (cool_done) begin
                    state_d = key_level_w ? ST_HELD : ST_IDLE;
                end
            end
            ST_HELD: begin
                if (!key_level_w) begin
                    state_d = ST_IDLE;
                end else if (rep_fire) begin
                    state_d = ST_COOLDOWN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        flap_d = ((state_q == ST_IDLE) && rise_q && gate_open) || rep_fire;
    end

    always_comb begin
        key_level_prev_d = key_level_w;
        rise_d           = key_level_w & ~key_level_prev_q;

        cool_cnt_d = '0;
        if (state_q == ST_COOLDOWN && !flap_q && !cool_done) begin
            cool_cnt_d = cool_cnt_q + 1'b1;
        end

        // A START_SCREEN cycle wipes the count even if a flap lands on the same cycle.
        flap_count_d = flap_count_q;
        if (game_state == GS_START_SCREEN) begin
            flap_count_d = '0;
        end else if (flap_q && game_state == GS_IN_GAME && flap_count_q != 16'hFFFF) begin
            flap_count_d = flap_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_level_prev_q <= 1'b0;
            rise_q           <= 1'b0;
            flap_q           <= 1'b0;
            cool_cnt_q       <= '0;
            flap_count_q     <= '0;
        end else begin
            key_level_prev_q <= key_level_prev_d;
            rise_q           <= rise_d;
            flap_q           <= flap_d;
            cool_cnt_q       <= cool_cnt_d;
            flap_count_q     <= flap_count_d;
        end
    end

    assign flap       = flap_q;
    assign key_level  = key_level_w;
    assign flap_count = flap_count_q;

endmodule
